median3x3_stream: RTL and testbench
===================================

# median3x3_stream

Streaming, pipelined 3×3 median filter for raster-scan pixel streams, parametrised in pixel width and image geometry. Two internal line buffers build the 3×3 window on the fly. The median network is split into three registered stages (row sort, column min/med/max, final median). Valid/ready handshakes on both sides let it sit between a pixel source and a downstream stage in the image-processing chain. A per-pixel bypass mode passes the window centre unfiltered.

## Interface
- DATA_W, 8, pixel width in bits (unsigned)
- IMG_W, 640, pixels per line (≥3)
- IMG_H, 480, lines per frame (≥3)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- s_valid  input  1  input pixel valid
- s_ready  output  1  block can accept input pixel
- s_data  input  DATA_W  input pixel, raster order
- s_sof  input  1  start of frame, qualified by s_valid && s_ready
- bypass  input  1  sampled with each accepted pixel; 1 = output window centre instead of median
- m_valid  output  1  output pixel valid
- m_ready  input  1  downstream accepts output
- m_data  output  DATA_W  filtered pixel
- m_last  output  1  marks the last output pixel of a frame

## Operation
- Accept on `s_valid && s_ready`. Global advance `en = !m_valid || m_ready`. `s_ready = en` (combinational from m_ready).
- Position counters:
  - col runs 0..IMG_W-1; row runs 0..IMG_H-1.
  - Both advance on each accept. col wraps to 0 and increments row; row wraps to 0 after the last pixel of the frame.
  - An accept with s_sof=1 treats that pixel as (0,0), whatever the counter state, and counting continues from there.
- Line buffers:
  - lb0 holds the previous line; lb1 holds the line before that. Each is depth IMG_W, addressed by col.
  - On accept: read lb1[col] and lb0[col]; write lb1[col]←lb0[col] and lb0[col]←s_data.
  - Window shifts left one column. The new right column is {lb1[col] (top), lb0[col] (middle), s_data (bottom)}.
- Window validity: the window is valid when the accepted pixel has row≥2 and col≥2. Its centre is then (row-1, col-1). Only interior pixels are output: (IMG_W-2)·(IMG_H-2) outputs per frame. Windows straddling a line wrap are never marked valid.
- Median network, all compares unsigned:
  - Stage 1: sort each window row into high/med/low.
  - Stage 2: take min of highs, median of meds, max of lows.
  - Stage 3: take the median of those three.
  - The result is the exact 5th-ranked value of the 9 pixels; ties are permitted.
- bypass and the window centre are carried alongside the data. At stage 3, m_data = bypass ? centre : median.
- m_last = 1 with the output whose centre is (IMG_H-2, IMG_W-2).
- Each stage holds a valid bit. All stages advance only when en=1. When en=1 and no accept occurs, a bubble (valid=0) enters the pipeline.
- Reset values:
  - m_valid=0, m_data=0, m_last=0. s_ready=1 after reset because m_valid=0.
  - Counters=0; all stage valid bits=0.
  - Line buffers and window registers are not reset; their contents are don't-care.

## Timing
- Latency: an accept at edge k of a pixel completing a valid window updates the window at k, stage 1 at k+1, stage 2 at k+2, and the output register at k+3. m_valid is visible after edge k+3.
- Throughput: 1 pixel/cycle while m_ready=1.
- Stall: with m_valid=1 and m_ready=0, m_data, m_last and m_valid hold. No stage, counter or line buffer changes, and s_ready=0.
- Simultaneous s_sof and counter wrap: s_sof wins; the pixel is (0,0).
- s_sof mid-frame: outputs already in the pipeline still drain. New windows become valid only from row 2 of the new frame.
- Reset mid-frame: m_valid drops asynchronously and in-flight pixels are discarded. The next accepted pixel is (0,0).

## Test plan
- IMG_W=5, IMG_H=4, continuous ramp pixel=5r+c, m_ready=1 -> exactly 6 outputs, 6,7,8,11,12,13; m_last only on 13.
- Same geometry, all pixels 10 except (1,1)=255 -> all outputs 10. Repeat with bypass=1 on pixel (2,2) -> first output is 255.
- DATA_W=12, window {4095×5, 0×4} -> median 4095. Window {0×5, 4095×4} -> median 0.
- Ramp frame with m_ready toggled pseudo-randomly -> same 6 values in order, none lost or duplicated. m_data stable during every m_valid && !m_ready cycle.
- Continuous stream -> first m_valid exactly 3 edges after the edge accepting pixel (2,2). Back-to-back outputs on consecutive cycles within a line.
- Assert s_sof at pixel (2,3) of frame 1, then send a full frame -> the drained outputs are followed by a correct 6-output frame. Assert rst_n=0 mid-frame -> m_valid=0 immediately; the next full frame yields correct outputs.

Source files
------------

// File: rtl/median3x3_stream.sv
// Streaming 3x3 median filter: two line buffers feed a sliding window, followed by
// a three-stage registered median network (row sort, column select, final median).
module median3x3_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_sof,
    input  logic              bypass,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef logic [DATA_W-1:0] pix_t;

    function automatic pix_t max2(input pix_t a, input pix_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic pix_t min2(input pix_t a, input pix_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    logic          en, accept;
    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    pix_t          lb0_q [IMG_W];
    pix_t          lb1_q [IMG_W];
    pix_t          lb0_rd, lb1_rd;
    pix_t          win_q [3][3];
    logic          win_byp_q, win_vld_q, win_last_q;
    pix_t          s1_hi_q [3];
    pix_t          s1_md_q [3];
    pix_t          s1_lo_q [3];
    pix_t          s1_ctr_q;
    logic          s1_byp_q, s1_vld_q, s1_last_q;
    pix_t          s2_hi_q, s2_md_q, s2_lo_q, s2_ctr_q;
    logic          s2_byp_q, s2_vld_q, s2_last_q;
    logic          m_valid_q, m_last_q;
    pix_t          m_data_q;

    assign en      = !m_valid_q || m_ready;
    assign s_ready = en;
    assign accept  = s_valid && en;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;

    // A start-of-frame pixel is position (0,0) regardless of where the counters are.
    always_comb begin
        cur_col = s_sof ? '0 : col_q;
        cur_row = s_sof ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (accept) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
        end
    end

    assign lb0_rd = lb0_q[cur_col];
    assign lb1_rd = lb1_q[cur_col];

    // Datapath storage carries no reset; only the valid/control bits are reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[cur_col] <= lb0_rd;
            lb0_q[cur_col] <= s_data;
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= lb1_rd;
            win_q[1][2] <= lb0_rd;
            win_q[2][2] <= s_data;
            win_byp_q   <= bypass;
        end
        if (en) begin
            for (int r = 0; r < 3; r++) begin
                s1_hi_q[r] <= max2(max2(win_q[r][0], win_q[r][1]), win_q[r][2]);
                s1_md_q[r] <= med3(win_q[r][0], win_q[r][1], win_q[r][2]);
                s1_lo_q[r] <= min2(min2(win_q[r][0], win_q[r][1]), win_q[r][2]);
            end
            s1_ctr_q <= win_q[1][1];
            s1_byp_q <= win_byp_q;
            s2_hi_q  <= min2(min2(s1_hi_q[0], s1_hi_q[1]), s1_hi_q[2]);
            s2_md_q  <= med3(s1_md_q[0], s1_md_q[1], s1_md_q[2]);
            s2_lo_q  <= max2(max2(s1_lo_q[0], s1_lo_q[1]), s1_lo_q[2]);
            s2_ctr_q <= s1_ctr_q;
            s2_byp_q <= s1_byp_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= '0;
            row_q      <= '0;
            win_vld_q  <= 1'b0;
            win_last_q <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_vld_q   <= 1'b0;
            s2_last_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            m_data_q   <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            if (en) begin
                win_vld_q  <= accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
                win_last_q <= accept && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
                s1_vld_q   <= win_vld_q;
                s1_last_q  <= win_last_q;
                s2_vld_q   <= s1_vld_q;
                s2_last_q  <= s1_last_q;
                m_valid_q  <= s2_vld_q;
                m_last_q   <= s2_vld_q && s2_last_q;
                if (s2_vld_q)
                    m_data_q <= s2_byp_q ? s2_ctr_q : med3(s2_hi_q, s2_md_q, s2_lo_q);
            end
        end
    end
endmodule

// File: tb/tb_median3x3_stream.sv
// Self-checking bench for median3x3_stream on a 5x4 image with 12-bit pixels; a
// frame model pushes expected outputs as pixels are queued, compared in order.
module tb_median3x3_stream;
    localparam int DW = 12;
    localparam int W  = 5;
    localparam int H  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0, s_sof = 1'b0, bypass = 1'b0, m_ready = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready, m_valid, m_last;
    logic [DW-1:0] m_data;

    always #5 clk = ~clk;

    median3x3_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_sof(s_sof), .bypass(bypass), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sof;
        logic          byp;
    } px_t;

    px_t           pix_q[$];
    logic [DW-1:0] exp_d[$];
    logic          exp_l[$];
    logic [DW-1:0] got_d[$];
    logic          got_l[$];
    int            got_cyc[$];
    int            acc_cyc[$];
    int            first_mv, stall_err, extra;
    bit            timeout;
    int            tests = 0, fails = 0;
    logic [DW-1:0] img [H][W];
    int            mr = 0, mc = 0;

    // Frame model: tracks position, stores pixels, emits the sorted 5th value per window.
    task automatic add_px(input logic [DW-1:0] d, input logic sof, input logic byp);
        logic [DW-1:0] w [9];
        logic [DW-1:0] t;
        int k;
        px_t p;
        p.d = d; p.sof = sof; p.byp = byp;
        pix_q.push_back(p);
        if (sof) begin mr = 0; mc = 0; end
        img[mr][mc] = d;
        if (mr >= 2 && mc >= 2) begin
            k = 0;
            for (int dr = 0; dr < 3; dr++)
                for (int dc = 0; dc < 3; dc++) begin
                    w[k] = img[mr-2+dr][mc-2+dc];
                    k = k + 1;
                end
            for (int i = 0; i < 9; i++)
                for (int j = 0; j < 8 - i; j++)
                    if (w[j] > w[j+1]) begin t = w[j]; w[j] = w[j+1]; w[j+1] = t; end
            exp_d.push_back(byp ? img[mr-1][mc-1] : w[4]);
            exp_l.push_back(mr == H-1 && mc == W-1);
        end
        if (mc == W-1) begin mc = 0; mr = (mr == H-1) ? 0 : mr + 1; end
        else mc = mc + 1;
    endtask

    task automatic add_ramp_frame();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                add_px(DW'(5*r + c), r == 0 && c == 0, 1'b0);
    endtask

    task automatic add_rand_frame();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                add_px(DW'($urandom_range(0, 4095)), r == 0 && c == 0, 1'b0);
    endtask

    // mode 0: m_ready=1, mode 1: random m_ready, mode 2: m_ready=0
    task automatic stream(input int mode, input int nout);
        int idx = 0, cyc = 0;
        bit pst = 1'b0;
        logic [DW-1:0] pd = '0;
        logic pl = 1'b0;
        got_d.delete(); got_l.delete(); got_cyc.delete(); acc_cyc.delete();
        first_mv = -1; stall_err = 0; timeout = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if ((idx >= pix_q.size() && got_d.size() >= nout) || cyc > 2000) begin
                if (cyc > 2000) timeout = 1'b1;
                s_valid = 1'b0; s_sof = 1'b0; bypass = 1'b0; m_ready = 1'b0;
                break;
            end
            if (idx < pix_q.size()) begin
                s_valid = 1'b1; s_data = pix_q[idx].d; s_sof = pix_q[idx].sof; bypass = pix_q[idx].byp;
            end else begin
                s_valid = 1'b0; s_sof = 1'b0; bypass = 1'b0;
            end
            m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            if (pst && (m_valid !== 1'b1 || m_data !== pd || m_last !== pl)) stall_err++;
            if (m_valid === 1'b1 && first_mv < 0) first_mv = cyc;
            if (m_valid === 1'b1 && m_ready) begin
                got_d.push_back(m_data); got_l.push_back(m_last); got_cyc.push_back(cyc);
            end
            if (s_valid && s_ready === 1'b1) begin acc_cyc.push_back(cyc); idx++; end
            pst = (m_valid === 1'b1) && !m_ready;
            pd = m_data; pl = m_last;
        end
        pix_q.delete();
    endtask

    task automatic drain_extra();
        extra = 0;
        m_ready = 1'b1;
        repeat (8) begin
            @(negedge clk); #1;
            if (m_valid === 1'b1) extra++;
        end
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if (m_valid !== 1'b0 || m_data !== '0 || m_last !== 1'b0) begin
            fails++;
            $display("FAIL reset outputs: got valid=%b data=%0d last=%b, want 0/0/0", m_valid, m_data, m_last);
        end
        tests++;
        if (s_ready !== 1'b1) begin fails++; $display("FAIL reset s_ready: got %b want 1", s_ready); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ramp();
        logic [DW-1:0] ref_v [6] = '{12'd6, 12'd7, 12'd8, 12'd11, 12'd12, 12'd13};
        add_ramp_frame();
        exp_d.delete(); exp_l.delete();
        stream(0, 6);
        tests++;
        if (timeout || got_d.size() != 6) begin
            fails++; $display("FAIL ramp count: got %0d outputs want 6 (timeout=%0d)", got_d.size(), timeout);
        end
        for (int i = 0; i < 6 && i < got_d.size(); i++) begin
            tests++;
            if (got_d[i] !== ref_v[i] || got_l[i] !== (i == 5)) begin
                fails++;
                $display("FAIL ramp out%0d: got %0d last=%b, want %0d last=%b", i, got_d[i], got_l[i], ref_v[i], i == 5);
            end
        end
        drain_extra();
        tests++;
        if (extra !== 0) begin fails++; $display("FAIL ramp extra outputs: got %0d want 0", extra); end
    endtask

    task automatic test_outlier_bypass();
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    add_px((r == 1 && c == 1) ? DW'(255) : DW'(10), r == 0 && c == 0, f == 1 && r == 2 && c == 2);
        stream(0, 12);
        tests++;
        if (timeout || got_d.size() != exp_d.size()) begin
            fails++; $display("FAIL outlier count: got %0d want %0d (timeout=%0d)", got_d.size(), exp_d.size(), timeout);
        end
        foreach (exp_d[i]) if (i < got_d.size()) begin
            tests++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                fails++;
                $display("FAIL outlier out%0d: got %0d last=%b, want %0d last=%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
        tests++;
        if (got_d.size() < 7 || got_d[0] !== DW'(10) || got_d[6] !== DW'(255)) begin
            fails++; $display("FAIL outlier bypass first: got %0d want 255 (plain first want 10)", got_d.size() > 6 ? got_d[6] : 0);
        end
        exp_d.delete(); exp_l.delete();
    endtask

    task automatic test_wide_extremes();
        logic [DW-1:0] v;
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++) begin
                    v = DW'($urandom_range(0, 4095));
                    if (r < 3 && c < 3) v = ((r*3 + c < 5) ^ (f == 1)) ? 12'hFFF : 12'h000;
                    add_px(v, r == 0 && c == 0, 1'b0);
                end
        stream(0, 12);
        tests++;
        if (timeout || got_d.size() != exp_d.size()) begin
            fails++; $display("FAIL wide count: got %0d want %0d (timeout=%0d)", got_d.size(), exp_d.size(), timeout);
        end
        foreach (exp_d[i]) if (i < got_d.size()) begin
            tests++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                fails++;
                $display("FAIL wide out%0d: got %0d last=%b, want %0d last=%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
        tests++;
        if (got_d.size() < 7 || got_d[0] !== 12'hFFF || got_d[6] !== 12'h000) begin
            fails++; $display("FAIL wide extremes: got %0d/%0d want 4095/0", got_d.size() > 0 ? got_d[0] : 0, got_d.size() > 6 ? got_d[6] : 0);
        end
        exp_d.delete(); exp_l.delete();
    endtask

    task automatic test_backpressure();
        add_ramp_frame();
        add_rand_frame();
        add_rand_frame();
        stream(1, 18);
        tests++;
        if (timeout || got_d.size() != exp_d.size()) begin
            fails++; $display("FAIL backpressure count: got %0d want %0d (timeout=%0d)", got_d.size(), exp_d.size(), timeout);
        end
        foreach (exp_d[i]) if (i < got_d.size()) begin
            tests++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                fails++;
                $display("FAIL backpressure out%0d: got %0d last=%b, want %0d last=%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
        tests++;
        if (stall_err !== 0) begin fails++; $display("FAIL stall hold: got %0d changes while stalled, want 0", stall_err); end
        drain_extra();
        tests++;
        if (extra !== 0) begin fails++; $display("FAIL backpressure extra outputs: got %0d want 0", extra); end
        exp_d.delete(); exp_l.delete();
    endtask

    task automatic test_back_to_back();
        add_ramp_frame();
        exp_d.delete(); exp_l.delete();
        stream(0, 6);
        tests++;
        if (acc_cyc.size() < 13 || first_mv !== acc_cyc[12] + 4) begin
            fails++; $display("FAIL latency: first m_valid at cycle %0d, want accept(2,2) cycle + 4 = %0d",
                              first_mv, acc_cyc.size() > 12 ? acc_cyc[12] + 4 : -1);
        end
        tests++;
        if (got_cyc.size() < 3 || got_cyc[1] !== got_cyc[0] + 1 || got_cyc[2] !== got_cyc[1] + 1) begin
            fails++; $display("FAIL back_to_back: output cycles not consecutive within a line (count %0d)", got_cyc.size());
        end
    endtask

    task automatic test_sof_mid();
        for (int i = 0; i < 2*W + 3; i++)
            add_px(DW'($urandom_range(0, 4095)), i == 0, 1'b0);
        add_ramp_frame();
        stream(0, 7);
        tests++;
        if (timeout || got_d.size() != exp_d.size()) begin
            fails++; $display("FAIL sof_mid count: got %0d want %0d (timeout=%0d)", got_d.size(), exp_d.size(), timeout);
        end
        foreach (exp_d[i]) if (i < got_d.size()) begin
            tests++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                fails++;
                $display("FAIL sof_mid out%0d: got %0d last=%b, want %0d last=%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
        tests++;
        if (got_d.size() < 2 || got_d[1] !== DW'(6)) begin
            fails++; $display("FAIL sof_mid new frame first: got %0d want 6", got_d.size() > 1 ? got_d[1] : 0);
        end
        drain_extra();
        tests++;
        if (extra !== 0) begin fails++; $display("FAIL sof_mid extra outputs: got %0d want 0", extra); end
        exp_d.delete(); exp_l.delete();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3*W; i++)
            add_px(DW'($urandom_range(0, 4095)), i == 0, 1'b0);
        stream(2, 0);
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (m_valid !== 1'b1) begin fails++; $display("FAIL reset_mid pre: m_valid got %b want 1", m_valid); end
        rst_n = 1'b0;
        #1;
        tests++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            fails++; $display("FAIL reset_mid async: got m_valid=%b s_ready=%b want 0/1", m_valid, s_ready);
        end
        @(negedge clk); rst_n = 1'b1;
        exp_d.delete(); exp_l.delete();
        mr = 0; mc = 0;
        add_rand_frame();
        stream(0, 6);
        tests++;
        if (timeout || got_d.size() != exp_d.size()) begin
            fails++; $display("FAIL reset_mid count: got %0d want %0d (timeout=%0d)", got_d.size(), exp_d.size(), timeout);
        end
        foreach (exp_d[i]) if (i < got_d.size()) begin
            tests++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                fails++;
                $display("FAIL reset_mid out%0d: got %0d last=%b, want %0d last=%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
        drain_extra();
        tests++;
        if (extra !== 0) begin fails++; $display("FAIL reset_mid extra outputs: got %0d want 0", extra); end
        exp_d.delete(); exp_l.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        test_reset();
        test_ramp();
        test_outlier_bypass();
        test_wide_extremes();
        test_backpressure();
        test_back_to_back();
        test_sof_mid();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
